// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame FSM states,
// frame bit constants and default timing parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;
    localparam int   FRAME_DATA_BITS = 8;

    localparam int FILTER_LEN_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT    = 100000;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic                       par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Scan-code handshake between the PS/2 receiver and the scan-code decoder.
interface ps2_scan_receiver_if;
    import ps2_pkg::*;

    logic                       read;
    logic                       scan_ready;
    logic [FRAME_DATA_BITS-1:0] scan_code;
    logic                       frame_err;
    logic                       overflow;

    modport master (
        input  read,
        output scan_ready,
        output scan_code,
        output frame_err,
        output overflow
    );

    modport slave (
        output read,
        input  scan_ready,
        input  scan_code,
        input  frame_err,
        input  overflow
    );

endinterface

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scan codes; dout is a registered copy
// of the head entry that holds its last value once the FIFO drains.
module ps2_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_next = rd_ptr + 1'b1;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head moves to the next stored entry, or to the incoming byte when
            // that byte becomes the only entry.
            if (do_pop && (count > CNT_W'(1))) begin
                dout <= mem[rd_next];
            end else if (do_push && (empty || (do_pop && (count == CNT_W'(1))))) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the pins, decodes
// 11-bit frames with parity/stop/timeout checks and queues good bytes.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int DEPTH      = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  PS2_CLK,
    input  logic                  PS2_DAT,
    ps2_scan_receiver_if.master   bus
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int BIT_W  = $clog2(FRAME_DATA_BITS);

    logic              clk_s1, clk_s2;
    logic              dat_s1, dat_s2;
    logic              filt_clk;
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_flip;
    logic              fall;

    ps2_state_e                 state_q, state_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic                       push;
    logic                       frame_err;

    logic fifo_full, fifo_empty;
    logic pop_gap_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock follows the pin only after FILTER_LEN agreeing samples.
    assign filt_flip = (clk_s2 != filt_clk) && (filt_cnt == FCNT_W'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = '0;
        shift_d   = shift_q;
        parity_d  = parity_q;
        push      = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall && (dat_s2 == START_BIT)) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2, shift_q[FRAME_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(FRAME_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = dat_s2;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if ((dat_s2 == STOP_BIT) && odd_parity_ok(shift_q, parity_q)) begin
                        push = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Inside a frame, a stalled device clock abandons the partial byte.
        if ((state_q != IDLE) && !fall) begin
            if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                state_d   = IDLE;
                frame_err = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_DATA_BITS)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (push),
        .pop   (bus.read),
        .din   (shift_q),
        .dout  (bus.scan_code),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One idle cycle after each pop gives edge-triggered consumers a fresh rising edge per byte.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pop_gap_q <= 1'b0;
        end else begin
            pop_gap_q <= bus.read && !fifo_empty;
        end
    end

    assign bus.scan_ready = !fifo_empty && !pop_gap_q;
    assign bus.frame_err  = frame_err;
    assign bus.overflow   = push && fifo_full && !bus.read;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: framed bytes, parity errors, overflow,
// timeout, clock glitches and reset mid-frame.
module tb_ps2_scan_receiver;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int DEPTH      = 4;
    localparam int HALF       = 40;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic PS2_CLK;
    logic PS2_DAT;

    ps2_scan_receiver_if bus();

    ps2_scan_receiver #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .DEPTH      (DEPTH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int ovf_pulses = 0;
    int both_pulses = 0;

    always @(negedge CLOCK_50) begin
        if (bus.frame_err === 1'b1) err_pulses++;
        if (bus.overflow === 1'b1) ovf_pulses++;
        if ((bus.frame_err === 1'b1) && (bus.overflow === 1'b1)) both_pulses++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
        logic par;
        par = (~^d) ^ bad_par;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b, input bit glitch);
        PS2_DAT = b;
        if (glitch) begin
            repeat (HALF / 2) tick();
            PS2_CLK = 1'b0;
            repeat (3) tick();
            PS2_CLK = 1'b1;
            repeat (HALF - HALF / 2 - 3) tick();
        end else begin
            repeat (HALF) tick();
        end
        PS2_CLK = 1'b0;
        repeat (HALF) tick();
        PS2_CLK = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
        for (int i = 0; i < n; i++) send_bit(f[i], glitch);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitch);
        send_bits(mk_frame(d, bad_par), 11, glitch);
        PS2_DAT = 1'b1;
        repeat (2 * HALF) tick();
    endtask

    task automatic do_read();
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
    endtask

    logic [7:0] exp_q [4];
    int e0;
    int o0;

    initial begin
        reset    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DAT  = 1'b1;
        bus.read = 1'b0;
        repeat (3) tick();
        check("rst_ready", bus.scan_ready, 0);
        check("rst_code", bus.scan_code, 8'h00);
        check("rst_err", bus.frame_err, 0);
        check("rst_ovf", bus.overflow, 0);
        reset = 1'b0;
        repeat (20) tick();

        // Valid 1C with exact ready latency around the stop-bit fall
        send_bits(mk_frame(8'h1C, 0), 10, 0);
        PS2_DAT = 1'b1;
        repeat (HALF) tick();
        PS2_CLK = 1'b0;
        repeat (FILTER_LEN + 1) tick();
        check("t1_ready_before_push", bus.scan_ready, 0);
        tick();
        check("t1_ready_after_push", bus.scan_ready, 1);
        check("t1_code", bus.scan_code, 8'h1C);
        repeat (HALF - FILTER_LEN - 2) tick();
        PS2_CLK = 1'b1;
        repeat (2 * HALF) tick();
        do_read();
        check("t1_ready_after_read", bus.scan_ready, 0);
        tick();
        check("t1_ready_empty", bus.scan_ready, 0);
        check("t1_code_hold", bus.scan_code, 8'h1C);

        // Bad parity, then a good 32
        e0 = err_pulses;
        send_frame(8'h1C, 1, 0);
        check("t2_err_pulse", err_pulses - e0, 1);
        check("t2_ready_low", bus.scan_ready, 0);
        send_frame(8'h32, 0, 0);
        check("t2_ready", bus.scan_ready, 1);
        check("t2_code", bus.scan_code, 8'h32);
        check("t2_no_extra_err", err_pulses - e0, 1);
        do_read();

        // Overflow on the fifth byte
        o0 = ovf_pulses;
        e0 = err_pulses;
        exp_q = '{8'hF0, 8'h1C, 8'h32, 8'h21};
        for (int i = 0; i < 4; i++) send_frame(exp_q[i], 0, 0);
        check("t3_no_ovf_yet", ovf_pulses - o0, 0);
        send_frame(8'h23, 0, 0);
        check("t3_ovf_pulse", ovf_pulses - o0, 1);
        check("t3_no_err", err_pulses - e0, 0);
        for (int i = 0; i < 4; i++) begin
            check("t3_ready", bus.scan_ready, 1);
            check("t3_code", bus.scan_code, exp_q[i]);
            do_read();
            check("t3_gap", bus.scan_ready, 0);
            tick();
        end
        check("t3_drained", bus.scan_ready, 0);

        // Timeout after four data bits
        e0 = err_pulses;
        send_bits(mk_frame(8'h55, 0), 5, 0);
        repeat (150) tick();
        check("t4_no_early_err", err_pulses - e0, 0);
        for (int i = 0; (i < TIMEOUT + 100) && (err_pulses == e0); i++) tick();
        check("t4_timeout_err", err_pulses - e0, 1);
        check("t4_ready_low", bus.scan_ready, 0);
        send_frame(8'h2B, 0, 0);
        check("t4_ready", bus.scan_ready, 1);
        check("t4_code", bus.scan_code, 8'h2B);
        check("t4_no_extra_err", err_pulses - e0, 1);
        do_read();
        tick();

        // Short low glitches while idle and within a frame
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) begin
            PS2_CLK = 1'b0;
            repeat (3) tick();
            PS2_CLK = 1'b1;
            repeat (20) tick();
        end
        check("t5_idle_ready", bus.scan_ready, 0);
        send_frame(8'h1C, 0, 1);
        check("t5_ready", bus.scan_ready, 1);
        check("t5_code", bus.scan_code, 8'h1C);
        check("t5_no_err", err_pulses - e0, 0);
        do_read();
        tick();

        // Reset mid-frame with two bytes queued
        send_frame(8'h21, 0, 0);
        send_frame(8'h23, 0, 0);
        check("t6_queued_ready", bus.scan_ready, 1);
        check("t6_queued_code", bus.scan_code, 8'h21);
        send_bits(mk_frame(8'h77, 0), 6, 0);
        reset = 1'b1;
        #1;
        check("t6_rst_ready", bus.scan_ready, 0);
        check("t6_rst_code", bus.scan_code, 8'h00);
        PS2_DAT = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        e0 = err_pulses;
        send_frame(8'h1A, 0, 0);
        check("t6_ready", bus.scan_ready, 1);
        check("t6_code", bus.scan_code, 8'h1A);
        check("t6_no_err", err_pulses - e0, 0);
        do_read();
        check("t6_gap", bus.scan_ready, 0);
        tick();
        check("t6_fifo_cleared", bus.scan_ready, 0);

        check("never_err_and_ovf", both_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
